// File: rtl/alsu_pkg.sv
// Shared types for the ALSU command driver: opcodes, command/response/pin
// structs, driver FSM states and the command-to-pin mapping.
// No logic of its own; no latency or backpressure.
package alsu_pkg;

    localparam int TAG_W = 4;

    typedef enum logic [2:0] {
        OR, XOR, ADD, MULT, SHIFT, ROTATE, INV6, INV7
    } alsu_opcode_e;

    typedef enum logic [1:0] {
        IDLE, RUN, STALL, DRAIN
    } driver_state_e;

    // 21-bit command word; the MSB is reserved padding and is ignored.
    typedef struct packed {
        logic               rsvd;
        alsu_opcode_e       opcode;
        logic [2:0]         a;
        logic [2:0]         b;
        logic               cin;
        logic               serial_in;
        logic               red_op_a;
        logic               red_op_b;
        logic               bypass_a;
        logic               bypass_b;
        logic               direction;
        logic [TAG_W-1:0]   tag;
    } alsu_cmd_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [5:0]         out;
        logic               invalid;
    } alsu_rsp_t;

    typedef struct packed {
        alsu_opcode_e       opcode;
        logic [2:0]         a;
        logic [2:0]         b;
        logic               cin;
        logic               serial_in;
        logic               red_op_a;
        logic               red_op_b;
        logic               bypass_a;
        logic               bypass_b;
        logic               direction;
    } alsu_pins_t;

    function automatic alsu_pins_t cmd_to_pins(input alsu_cmd_t c);
        alsu_pins_t p;
        p.opcode    = c.opcode;
        p.a         = c.a;
        p.b         = c.b;
        p.cin       = c.cin;
        p.serial_in = c.serial_in;
        p.red_op_a  = c.red_op_a;
        p.red_op_b  = c.red_op_b;
        p.bypass_a  = c.bypass_a;
        p.bypass_b  = c.bypass_b;
        p.direction = c.direction;
        return p;
    endfunction

endpackage

// File: rtl/alsu_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; clr empties it and wins over a push.
// Latency: a push is visible on pop_dat the cycle after the write edge.
// Backpressure: push ignored when full unless a pop frees the slot; pop ignored when empty.
module alsu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/alsu_cmd_driver.sv
// Queues ALSU commands, drives the registered ALSU pins and captures tagged results in order.
// Latency: accept to rsp_valid is ALSU_LAT+2 cycles when idle and unstalled.
// Backpressure: issue only with a free response slot reserved; cmd_ready drops when cmd FIFO full or draining.
module alsu_cmd_driver
    import alsu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALSU_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  alsu_cmd_t   cmd_data,
    output logic [2:0]  alsu_opcode,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_red_op_a,
    output logic        alsu_red_op_b,
    output logic        alsu_bypass_a,
    output logic        alsu_bypass_b,
    output logic        alsu_direction,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_tag,
    output logic [5:0]  rsp_out,
    output logic        rsp_invalid,
    input  logic        flush,
    output logic        idle
);

    localparam int CMD_W = $bits(alsu_cmd_t);
    localparam int RSP_W = $bits(alsu_rsp_t);
    localparam int IF_W  = $clog2(ALSU_LAT + 2);
    localparam int SUM_W = $clog2(RSP_DEPTH + ALSU_LAT + 2) + 1;
    localparam logic [IF_W-1:0] IF_ONE = 1;

    driver_state_e                  state_q, state_d;
    alsu_pins_t                     pins_q, pins_d;
    logic [IF_W-1:0]                in_flight_q, in_flight_d;
    logic [ALSU_LAT:0]              pipe_vld_q, pipe_vld_d;
    logic [ALSU_LAT:0][TAG_W-1:0]   pipe_tag_q, pipe_tag_d;
    logic                           ready_en_q, ready_en_d;

    alsu_cmd_t                      cmd_head;
    alsu_rsp_t                      rsp_head;
    alsu_rsp_t                      rsp_wr_dat;
    logic                           cmd_full, cmd_empty, cmd_push;
    logic                           rsp_empty, rsp_wr;
    logic [$clog2(RSP_DEPTH):0]     rsp_cnt;
    logic                           credit_ok, issue;
    logic [$clog2(CMD_DEPTH):0]     unused_cmd_cnt;
    logic                           unused_rsp_full;
    logic                           unused_rsvd;

    assign cmd_ready   = ready_en_q && !cmd_full && (state_q != DRAIN);
    assign cmd_push    = cmd_valid && cmd_ready && !flush;
    // A slot is reserved per in-flight op, so the result write can never overflow.
    assign credit_ok   = (SUM_W'(in_flight_q) + SUM_W'(rsp_cnt)) < SUM_W'(RSP_DEPTH);
    assign issue       = !cmd_empty && (state_q == RUN) && credit_ok && !flush;
    assign rsp_wr      = pipe_vld_q[ALSU_LAT];
    assign rsp_wr_dat  = '{tag: pipe_tag_q[ALSU_LAT], out: alsu_out, invalid: |alsu_leds};
    assign unused_rsvd = cmd_head.rsvd;

    alsu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .push     (cmd_push),
        .push_dat (cmd_data),
        .pop      (issue),
        .pop_dat  (cmd_head),
        .full     (cmd_full),
        .empty    (cmd_empty),
        .count    (unused_cmd_cnt)
    );

    alsu_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .push     (rsp_wr),
        .push_dat (rsp_wr_dat),
        .pop      (rsp_ready),
        .pop_dat  (rsp_head),
        .full     (unused_rsp_full),
        .empty    (rsp_empty),
        .count    (rsp_cnt)
    );

    always_comb begin
        state_d     = state_q;
        pins_d      = pins_q;
        in_flight_d = in_flight_q;
        ready_en_d  = 1'b1;
        pipe_vld_d  = {pipe_vld_q[ALSU_LAT-1:0], issue};
        pipe_tag_d  = {pipe_tag_q[ALSU_LAT-1:0], cmd_head.tag};

        if (issue) pins_d = cmd_to_pins(cmd_head);

        case ({issue, rsp_wr})
            2'b10:   in_flight_d = in_flight_q + IF_ONE;
            2'b01:   in_flight_d = in_flight_q - IF_ONE;
            default: in_flight_d = in_flight_q;
        endcase

        unique case (state_q)
            IDLE:  if (!cmd_empty || cmd_push) state_d = RUN;
            RUN: begin
                if (cmd_empty && !cmd_push)      state_d = IDLE;
                else if (!cmd_empty && !credit_ok) state_d = STALL;
            end
            STALL: if (credit_ok) state_d = RUN;
            DRAIN: if (in_flight_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) state_d = DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pins_q      <= '0;
            in_flight_q <= '0;
            pipe_vld_q  <= '0;
            pipe_tag_q  <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pins_q      <= pins_d;
            in_flight_q <= in_flight_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_tag_q  <= pipe_tag_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign alsu_opcode    = pins_q.opcode;
    assign alsu_a         = pins_q.a;
    assign alsu_b         = pins_q.b;
    assign alsu_cin       = pins_q.cin;
    assign alsu_serial_in = pins_q.serial_in;
    assign alsu_red_op_a  = pins_q.red_op_a;
    assign alsu_red_op_b  = pins_q.red_op_b;
    assign alsu_bypass_a  = pins_q.bypass_a;
    assign alsu_bypass_b  = pins_q.bypass_b;
    assign alsu_direction = pins_q.direction;

    assign rsp_valid   = !rsp_empty;
    assign rsp_tag     = rsp_head.tag;
    assign rsp_out     = rsp_head.out;
    assign rsp_invalid = rsp_head.invalid;

    assign idle = cmd_empty && rsp_empty && (in_flight_q == '0) && (state_q == IDLE);

endmodule
